// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, op codes,
// FSM states and the operand magnitude helper.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Two's-complement magnitude when the operation treats the value as signed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH-1:0] m;
    if (is_signed && v[WIDTH-1]) begin
      m = ~v + WIDTH'(1);
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one step per cycle, sign fix-up on the final step.
module muldiv_unit #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  import muldiv_pkg::*;

  localparam logic [4:0] LAST_CNT = 5'(ITERS - 1);

  state_e               state_r;
  logic [4:0]           cnt_r;
  op_e                  op_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   acc_r;

  logic                 in_signed_s;
  logic [WIDTH-1:0]     in_mag_a_s;
  logic [WIDTH-1:0]     in_mag_b_s;
  logic                 is_mul_s;
  logic                 is_signed_s;
  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       rem_ext_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     rem_sub_s;
  logic [2*WIDTH-1:0]   acc_nxt_s;
  logic                 neg_res_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     hi_nxt_s;
  logic [WIDTH-1:0]     lo_nxt_s;
  logic                 dbz_nxt_s;

  // Operand magnitudes of the incoming request, used to seed the accumulator.
  always_comb begin
    in_signed_s = ~op[0];
    in_mag_a_s  = magnitude(a_in, in_signed_s);
    in_mag_b_s  = magnitude(b_in, in_signed_s);
  end

  // Decode of the latched operation and magnitudes of the latched operands.
  always_comb begin
    case (op_r)
      OP_MULT: begin
        is_mul_s    = 1'b1;
        is_signed_s = 1'b1;
      end
      OP_MULTU: begin
        is_mul_s    = 1'b1;
        is_signed_s = 1'b0;
      end
      OP_DIV: begin
        is_mul_s    = 1'b0;
        is_signed_s = 1'b1;
      end
      OP_DIVU: begin
        is_mul_s    = 1'b0;
        is_signed_s = 1'b0;
      end
      default: begin
        is_mul_s    = 1'b0;
        is_signed_s = 1'b0;
      end
    endcase
    mag_a_s = magnitude(a_r, is_signed_s);
    mag_b_s = magnitude(b_r, is_signed_s);
  end

  // One iteration step. Multiply keeps the multiplier in the low half and shifts
  // right; divide keeps {remainder, dividend/quotient} and shifts left.
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_r[0] ? mag_a_s : {WIDTH{1'b0}})};
    rem_ext_s = acc_r[2*WIDTH-1:WIDTH-1];
    div_ge_s  = (rem_ext_s >= {1'b0, mag_b_s});
    rem_sub_s = WIDTH'(rem_ext_s - {1'b0, mag_b_s});
    if (is_mul_s) begin
      acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else if (div_ge_s) begin
      acc_nxt_s = {rem_sub_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction applied to the final iteration's accumulator.
  always_comb begin
    neg_res_s = is_signed_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    prod_s    = neg_res_s ? (~acc_nxt_s + (2*WIDTH)'(1)) : acc_nxt_s;
    quo_s     = acc_nxt_s[WIDTH-1:0];
    rem_s     = acc_nxt_s[2*WIDTH-1:WIDTH];
    if (is_mul_s) begin
      hi_nxt_s  = prod_s[2*WIDTH-1:WIDTH];
      lo_nxt_s  = prod_s[WIDTH-1:0];
      dbz_nxt_s = 1'b0;
    end else if (b_r == {WIDTH{1'b0}}) begin
      // Divide by zero reports the raw dividend, not its magnitude.
      hi_nxt_s  = a_r;
      lo_nxt_s  = {WIDTH{1'b1}};
      dbz_nxt_s = 1'b1;
    end else begin
      lo_nxt_s  = neg_res_s ? (~quo_s + WIDTH'(1)) : quo_s;
      hi_nxt_s  = (is_signed_s && a_r[WIDTH-1]) ? (~rem_s + WIDTH'(1)) : rem_s;
      dbz_nxt_s = 1'b0;
    end
  end

  // Control FSM with registered status/result outputs and the datapath state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      op_r        <= OP_MULT;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
            cnt_r   <= 5'd0;
            op_r    <= op_e'(op);
            a_r     <= a_in;
            b_r     <= b_in;
            acc_r   <= op[1] ? {{WIDTH{1'b0}}, in_mag_a_s}
                             : {{WIDTH{1'b0}}, in_mag_b_s};
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_r <= acc_nxt_s;
          if (cnt_r == LAST_CNT) begin
            state_r     <= ST_DONE;
            done        <= 1'b1;
            hi          <= hi_nxt_s;
            lo          <= lo_nxt_s;
            div_by_zero <= dbz_nxt_s;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an arithmetic reference model with a
// cycle-level protocol tracker, directed corner cases and randomized traffic.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {div_by_zero, hi, lo} straight from the arithmetic definition.
  function automatic logic [64:0] model_op(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] h, l;
    logic z;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    h = 32'd0;
    l = 32'd0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin l = 32'hFFFFFFFF; h = a; z = 1'b1; end
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin l = 32'hFFFFFFFF; h = a; z = 1'b1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
    return {z, h, l};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Protocol model: m_left counts the cycles of busy remaining after an accept.
  int          m_left;
  logic [64:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic        m_dbz;

  // Reference model state advance on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_dbz  <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend <= model_op(op, a_in, b_in);
        m_left <= 33;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_dbz <= m_pend[64];
        m_hi  <= m_pend[63:32];
        m_lo  <= m_pend[31:0];
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'd0, busy}, {63'd0, m_left > 0});
      check("done", {63'd0, done}, {63'd0, m_left == 1});
      check("hi", {32'd0, hi}, {32'd0, m_hi});
      check("lo", {32'd0, lo}, {32'd0, m_lo});
      check("div_by_zero", {63'd0, div_by_zero}, {63'd0, m_dbz});
    end
  end

  // Issue one op, optionally injecting a start or reset at a given RUN offset.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_start, input int inj_reset,
                        output int lat, output logic got_done);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    lat = 0;
    got_done = 1'b0;
    while (lat < 60 && !got_done) begin
      @(negedge clk);
      lat++;
      if (done) got_done = 1'b1;
      if (inj_reset > 0 && lat == inj_reset + 1) begin
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
      end
      start = (lat == inj_start);
      reset = (lat == inj_reset);
      op = 2'($urandom);
      a_in = $urandom;
      b_in = $urandom;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'd0;
      1: v = 32'hFFFFFFFF;
      2: v = 32'h80000000;
      3: v = 32'($urandom_range(0, 15));
      4: v = 32'd0 - 32'($urandom_range(1, 15));
      5: v = 32'h7FFFFFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  int   lat;
  logic got;
  logic [64:0] mr;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a_in = 32'd0; b_in = 32'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;

    // Pin the model itself against hand-computed values.
    mr = model_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("model_multu", mr, {1'b0, 32'hFFFFFFFE, 32'h00000001});
    mr = model_op(2'b00, 32'hFFFFFFFD, 32'd7);
    check("model_mult", mr, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
    mr = model_op(2'b10, 32'hFFFFFFF9, 32'd2);
    check("model_div", mr, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    mr = model_op(2'b11, 32'd100, 32'd0);
    check("model_dbz", mr, {1'b1, 32'h00000064, 32'hFFFFFFFF});
    mr = model_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    check("model_ovf", mr, {1'b0, 32'h00000000, 32'h80000000});

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, lat, got);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_hi", {32'd0, hi}, 64'hFFFFFFFE);
    check("multu_lo", {32'd0, lo}, 64'h00000001);

    run_op(2'b00, 32'hFFFFFFFD, 32'd7, 0, 0, lat, got);
    check("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("mult_lo", {32'd0, lo}, 64'hFFFFFFEB);

    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, 0, lat, got);
    check("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
    check("div_hi", {32'd0, hi}, 64'hFFFFFFFF);

    run_op(2'b11, 32'd100, 32'd0, 0, 0, lat, got);
    check("dbz_lat", 64'(lat), 64'd33);
    check("dbz_lo", {32'd0, lo}, 64'hFFFFFFFF);
    check("dbz_hi", {32'd0, hi}, 64'h00000064);
    check("dbz_flag", {63'd0, div_by_zero}, 64'd1);

    run_op(2'b11, 32'd100, 32'd7, 0, 0, lat, got);
    check("divu_lo", {32'd0, lo}, 64'd14);
    check("divu_hi", {32'd0, hi}, 64'd2);
    check("divu_flag", {63'd0, div_by_zero}, 64'd0);

    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, lat, got);
    check("ovf_lo", {32'd0, lo}, 64'h80000000);
    check("ovf_hi", {32'd0, hi}, 64'h00000000);

    // A start during RUN must be dropped; result follows the first operands.
    run_op(2'b01, 32'd5, 32'd6, 6, 0, lat, got);
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_lo", {32'd0, lo}, 64'd30);
    @(negedge clk);
    check("ign_idle", {63'd0, busy}, 64'd0);

    // Reset mid-RUN aborts, then a fresh op completes.
    run_op(2'b01, 32'd9, 32'd9, 0, 11, lat, got);
    check("abort_nodone", {63'd0, got}, 64'd0);
    run_op(2'b01, 32'd12, 32'd13, 0, 0, lat, got);
    check("fresh_lat", 64'(lat), 64'd33);
    check("fresh_lo", {32'd0, lo}, 64'd156);

    // Start held from DONE into IDLE: ignored in DONE, accepted in IDLE.
    run_op(2'b11, 32'd50, 32'd5, 0, 0, lat, got);
    start = 1'b1; op = 2'b11; a_in = 32'd81; b_in = 32'd9;
    @(negedge clk);
    check("b2b_idle", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("b2b_accept", {63'd0, busy}, 64'd1);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("b2b_lo", {32'd0, lo}, 64'd9);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom);
      a_in  = pick();
      b_in  = pick();
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a_in  input  32  operand A (multiplicand / dividend), taken from the A operand register.
REQ-007 b_in  input  32  operand B (multiplier / divisor), taken from the B operand register.
REQ-008 busy  output  1  high from the accept edge until the DONE cycle ends.
REQ-009 done  output  1  single-cycle completion strobe.
REQ-010 hi  output  32  MULT*: upper product; DIV*: remainder.
REQ-011 lo  output  32  MULT*: lower product; DIV*: quotient.
REQ-012 div_by_zero  output  1  flag for the last completed DIV/DIVU with b=0; held until the next completion.

Function
REQ-013 States: IDLE, RUN, DONE. IDLE->RUN on start=1; RUN->DONE when cnt=31; DONE->IDLE unconditionally.
REQ-014 On the accept edge, latch a_in, b_in and op, and set cnt=0; operand changes after that edge have no effect.
REQ-015 RUN performs one iteration per cycle for exactly 32 cycles (cnt 0..31, 5-bit, no wrap beyond 31).
REQ-016 Multiply: shift-add on operand magnitudes into a 64-bit accumulator.
REQ-017 Divide: restoring division on operand magnitudes, one quotient bit per cycle.
REQ-018 Signed ops: negate the result when operand signs differ (MULT, DIV quotient); the DIV remainder takes the sign of the dividend; the quotient truncates toward zero.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
REQ-020 Divide by zero: lo=0xFFFFFFFF, hi=a_in as latched, div_by_zero=1; latency is unchanged (full 32 RUN cycles).
REQ-021 hi, lo and div_by_zero update only on the RUN->DONE edge; they hold between operations.
REQ-022 Latency: start accepted at edge k -> done=1 in the cycle following edge k+32; results are valid in that cycle.
REQ-023 done=1 only in DONE; busy=1 in RUN and DONE; busy=0 in IDLE.
REQ-024 start in RUN or DONE is ignored, not queued; start=1 held in IDLE is accepted on the first IDLE edge.
REQ-025 Back-to-back: a start asserted during DONE is ignored; a start in the next (IDLE) cycle is accepted.

Reset
REQ-026 When reset=1 at an edge: state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, div_by_zero=0, internal accumulators=0.
REQ-027 Reset has priority over start.
REQ-028 Reset mid-RUN aborts the operation: no done is issued and no partial result reaches hi/lo.

Structure
REQ-029 Shared package muldiv_pkg holds: op encodings, the state enum, WIDTH=32 and the iteration count 32.
REQ-030 Single module with no sub-module; sign correction and the iteration datapath are inline.

Verification
REQ-031 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1, same latency; a following DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-035 start pulsed at RUN cycle 5 with different operands -> ignored; the result reflects the first operands only.
REQ-036 reset asserted at RUN cycle 10 -> busy=0 and hi=lo=0 on the next cycle; no done pulse; a fresh start then completes normally.
